// File: rtl/frame_sync_pkg.sv
// Shared definitions for the frame synchronisation controller.
//   - sync_state_e : controller states HUNT / VERIFY / LOCK
//   - DEF_SYNC_LEN / DEF_SYNC_CODE : default sync pattern (bit 0 received first)
//   - cnt_width()  : width of the in-frame bit counter
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } sync_state_e;

    localparam int          DEF_SYNC_LEN  = 4;
    localparam logic [15:0] DEF_SYNC_CODE = 16'h0009;

    // Counter must hold 0 .. payload_bits+sync_len-1.
    function automatic int cnt_width(input int payload_bits, input int sync_len);
        return $clog2(payload_bits + sync_len);
    endfunction

endpackage

// File: rtl/frame_sync_ctrl_sync_window_match.sv
// Sliding sync window with fill counter and comparator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bit_i      : serial data bit
//   vld_i      : qualifies bit_i; window and fill counter advance only when set
//   match_o    : combinational; high when the window *including* the current
//                bit equals SYNC_CODE and at least SYNC_LEN bits have arrived
module sync_window_match #(
    parameter int                  SYNC_LEN  = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_CODE = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_i,
    input  logic vld_i,
    output logic match_o
);

    localparam int            FW       = $clog2(SYNC_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_LEN);

    logic [SYNC_LEN-1:0] win_q, win_d;
    logic [FW-1:0]       fill_q, fill_d;

    // The match looks at the next window value so the controller can act on
    // the bit being sampled this cycle and still register its response.
    always_comb begin
        win_d   = {bit_i, win_q[SYNC_LEN-1:1]};
        fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        match_o = vld_i && (fill_d == FILL_MAX) && (win_d == SYNC_CODE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (vld_i) begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation controller: hunts for SYNC_CODE, verifies it recurs
// every frame, locks, then checks every sync slot and deserialises payload.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit_in       : serial data, sampled when bit_vld=1
//   bit_vld      : bit qualifier
//   locked       : high while in LOCK
//   frame_start  : pulse, good sync while locked or on entry to LOCK
//   sync_miss    : pulse, expected sync slot mismatched while locked
//   byte_out     : last deserialised byte (first received bit in [7])
//   byte_vld     : pulse, byte_out updated
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int                  SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_CODE    = DEF_SYNC_CODE[SYNC_LEN-1:0],
    parameter int                  PAYLOAD_BITS = 16,
    parameter int                  LOCK_CNT     = 2,
    parameter int                  UNLOCK_CNT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_vld,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_miss,
    output logic [7:0] byte_out,
    output logic       byte_vld
);

    localparam int            CW          = cnt_width(PAYLOAD_BITS, SYNC_LEN);
    localparam logic [CW-1:0] LAST_BIT    = CW'(PAYLOAD_BITS + SYNC_LEN - 1);
    localparam logic [CW-1:0] PAYLOAD_END = CW'(PAYLOAD_BITS);
    localparam int            GW          = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_CNT);
    localparam int            MW          = $clog2(UNLOCK_CNT + 1);
    localparam logic [MW-1:0] MISS_LIMIT  = MW'(UNLOCK_CNT);

    sync_state_e   state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    byte_out_q, byte_out_d;
    logic          byte_vld_q, byte_vld_d;
    logic          frame_start_q, frame_start_d;
    logic          sync_miss_q, sync_miss_d;
    logic          locked_q, locked_d;
    logic          match;
    logic          slot_end;

    sync_window_match #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_CODE (SYNC_CODE)
    ) u_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bit_in),
        .vld_i   (bit_vld),
        .match_o (match)
    );

    assign slot_end = (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        good_cnt_d    = good_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        shreg_d       = shreg_q;
        byte_out_d    = byte_out_q;
        byte_vld_d    = 1'b0;
        frame_start_d = 1'b0;
        sync_miss_d   = 1'b0;

        if (bit_vld) begin
            case (state_q)
                HUNT: begin
                    if (match) begin
                        bit_cnt_d  = '0;
                        good_cnt_d = GW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d       = LOCK;
                            frame_start_d = 1'b1;
                            miss_cnt_d    = '0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    if (slot_end) begin
                        bit_cnt_d = '0;
                        if (match) begin
                            if (good_cnt_q + GW'(1) == GOOD_TARGET) begin
                                state_d       = LOCK;
                                frame_start_d = 1'b1;
                                miss_cnt_d    = '0;
                            end
                            good_cnt_d = good_cnt_q + GW'(1);
                        end else begin
                            state_d    = HUNT;
                            good_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end

                LOCK: begin
                    // Payload is byte-aligned to the frame, so the low three
                    // counter bits give the position within the current byte.
                    if (bit_cnt_q < PAYLOAD_END) begin
                        shreg_d = {shreg_q[6:0], bit_in};
                        if (bit_cnt_q[2:0] == 3'b111) begin
                            byte_out_d = shreg_d;
                            byte_vld_d = 1'b1;
                        end
                    end
                    if (slot_end) begin
                        // Flywheel: the frame grid is kept even on a miss.
                        bit_cnt_d = '0;
                        if (match) begin
                            frame_start_d = 1'b1;
                            miss_cnt_d    = '0;
                        end else begin
                            sync_miss_d = 1'b1;
                            if (miss_cnt_q + MW'(1) == MISS_LIMIT) begin
                                state_d    = HUNT;
                                miss_cnt_d = '0;
                                good_cnt_d = '0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + MW'(1);
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end

                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            bit_cnt_q     <= '0;
            good_cnt_q    <= '0;
            miss_cnt_q    <= '0;
            shreg_q       <= '0;
            byte_out_q    <= '0;
            byte_vld_q    <= 1'b0;
            frame_start_q <= 1'b0;
            sync_miss_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            good_cnt_q    <= good_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            shreg_q       <= shreg_d;
            byte_out_q    <= byte_out_d;
            byte_vld_q    <= byte_vld_d;
            frame_start_q <= frame_start_d;
            sync_miss_q   <= sync_miss_d;
            locked_q      <= locked_d;
        end
    end

    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_miss   = sync_miss_q;
    assign byte_out    = byte_out_q;
    assign byte_vld    = byte_vld_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: scenario vectors are built as
// {bit, expected outputs} records, applied one per valid bit, and expected
// responses are queued and compared one cycle later.
module tb_frame_sync_ctrl;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_vld;
    logic       locked;
    logic       frame_start;
    logic       sync_miss;
    logic [7:0] byte_out;
    logic       byte_vld;

    frame_sync_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_miss   (sync_miss),
        .byte_out    (byte_out),
        .byte_vld    (byte_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic       fs;
        logic       miss;
        logic       bv;
        logic [7:0] bo;
    } exp_t;

    typedef struct {
        logic b;
        exp_t e;
    } vec_t;

    localparam logic [3:0] GOOD = 4'b1001;
    localparam logic [3:0] BAD  = 4'b1101;   // received as 1,0,1,1

    vec_t       vecs[$];
    exp_t       sb[$];
    exp_t       last_e;
    logic       m_locked;
    logic [7:0] m_byte;
    int         n_checks;
    int         n_pass;
    string      tag;

    // ---------------- vector building ----------------
    task automatic add_bit(input logic b, input logic fs, input logic miss,
                           input logic bv, input logic [7:0] bo, input logic lk);
        vec_t v;
        v.b      = b;
        v.e.lk   = lk;
        v.e.fs   = fs;
        v.e.miss = miss;
        v.e.bv   = bv;
        v.e.bo   = bo;
        vecs.push_back(v);
    endtask

    task automatic add_raw(input logic b);
        add_bit(b, 1'b0, 1'b0, 1'b0, m_byte, m_locked);
    endtask

    // MSB first: the first received bit lands in byte_out[7].
    task automatic add_byte(input logic [7:0] val, input logic emit);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && emit) begin
                m_byte = val;
                add_bit(val[0], 1'b0, 1'b0, 1'b1, val, m_locked);
            end else begin
                add_raw(val[i]);
            end
        end
    endtask

    task automatic add_sync(input logic [3:0] code, input logic fs,
                            input logic miss, input logic lk_after);
        for (int i = 0; i < 3; i++) add_raw(code[i]);
        m_locked = lk_after;
        add_bit(code[3], fs, miss, 1'b0, m_byte, m_locked);
    endtask

    // Hunt hit, verify frame, lock on 2nd sync, locked frame with 2 bytes.
    task automatic build_acquire();
        add_sync(GOOD, 1'b0, 1'b0, 1'b0);
        add_byte(8'hA5, 1'b0);
        add_byte(8'h3C, 1'b0);
        add_sync(GOOD, 1'b1, 1'b0, 1'b1);
        add_byte(8'h12, 1'b1);
        add_byte(8'h34, 1'b1);
        add_sync(GOOD, 1'b1, 1'b0, 1'b1);
    endtask

    // ---------------- application / checking ----------------
    task automatic check_pending();
        exp_t x;
        exp_t a;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            a = {locked, frame_start, sync_miss, byte_vld, byte_out};
            n_checks++;
            if (a === x) n_pass++;
            else $display("FAIL %s: got lk=%b fs=%b miss=%b bv=%b byte=%02h, want lk=%b fs=%b miss=%b bv=%b byte=%02h",
                          tag, a.lk, a.fs, a.miss, a.bv, a.bo, x.lk, x.fs, x.miss, x.bv, x.bo);
        end
    endtask

    task automatic check_now(input string name);
        exp_t a;
        a = {locked, frame_start, sync_miss, byte_vld, byte_out};
        n_checks++;
        if (a === '0) n_pass++;
        else $display("FAIL %s: got lk=%b fs=%b miss=%b bv=%b byte=%02h, want all zero",
                      name, a.lk, a.fs, a.miss, a.bv, a.bo);
    endtask

    task automatic cycle(input logic v, input logic b, input exp_t e);
        @(negedge clk);
        check_pending();
        bit_vld = v;
        bit_in  = b;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        check_pending();
        bit_vld = 1'b0;
    endtask

    task automatic run_vecs(input int max_gap);
        exp_t idle;
        for (int i = 0; i < vecs.size(); i++) begin
            if (max_gap > 0) begin
                idle      = last_e;
                idle.fs   = 1'b0;
                idle.miss = 1'b0;
                idle.bv   = 1'b0;
                repeat ($urandom_range(0, max_gap))
                    cycle(1'b0, 1'($urandom_range(0, 1)), idle);
            end
            cycle(1'b1, vecs[i].b, vecs[i].e);
            last_e = vecs[i].e;
        end
        drain();
        vecs.delete();
    endtask

    // Reset asserted between clock edges; outputs must clear with no edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_now(name);
        @(negedge clk);
        rst_n    = 1'b1;
        sb.delete();
        last_e   = '0;
        m_locked = 1'b0;
        m_byte   = 8'h00;
    endtask

    initial begin
        rst_n    = 1'b0;
        bit_vld  = 1'b0;
        bit_in   = 1'b0;
        last_e   = '0;
        m_locked = 1'b0;
        m_byte   = 8'h00;
        n_checks = 0;
        n_pass   = 0;

        // Reset held with random traffic: outputs stay at zero.
        tag = "reset_hold";
        repeat (8) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), exp_t'(0));
        drain();
        check_now("reset_hold_end");
        rst_n = 1'b1;

        // Acquire, then drop reset mid-byte while locked.
        tag = "acquire";
        add_raw(1'b0);
        add_raw(1'b0);
        build_acquire();
        add_raw(1'b1);
        add_raw(1'b0);
        add_raw(1'b1);
        run_vecs(0);
        do_reset("async_reset_mid_frame");

        // Verify failure, then a clean acquisition, then flywheel.
        tag = "verify_fail";
        add_sync(GOOD, 1'b0, 1'b0, 1'b0);
        add_byte(8'hF0, 1'b0);
        add_byte(8'h0F, 1'b0);
        add_sync(BAD, 1'b0, 1'b0, 1'b0);
        build_acquire();
        run_vecs(0);

        tag = "flywheel";
        add_byte(8'h11, 1'b1); add_byte(8'h22, 1'b1);
        add_sync(BAD,  1'b0, 1'b1, 1'b1);
        add_byte(8'h33, 1'b1); add_byte(8'h44, 1'b1);
        add_sync(BAD,  1'b0, 1'b1, 1'b1);
        add_byte(8'h55, 1'b1); add_byte(8'h66, 1'b1);
        add_sync(GOOD, 1'b1, 1'b0, 1'b1);
        add_byte(8'h77, 1'b1); add_byte(8'h88, 1'b1);
        add_sync(BAD,  1'b0, 1'b1, 1'b1);
        add_byte(8'h99, 1'b1); add_byte(8'hAA, 1'b1);
        add_sync(BAD,  1'b0, 1'b1, 1'b1);
        add_byte(8'hBB, 1'b1); add_byte(8'hCC, 1'b1);
        add_sync(BAD,  1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) add_raw(1'b0);
        run_vecs(0);
        do_reset("reset_after_flywheel");

        // Acquire with random idle cycles between bits.
        tag = "gapped";
        add_raw(1'b0);
        add_raw(1'b0);
        build_acquire();
        run_vecs(3);
        do_reset("reset_after_gapped");

        // Overlap: 1,0,0,1,0,0,1 hits on bit 4; bits 5..7 are payload, so
        // lock only lands on the slot 20 bits after that first hit.
        tag = "overlap";
        add_raw(1'b1); add_raw(1'b0); add_raw(1'b0); add_raw(1'b1);
        add_byte(8'h2B, 1'b0);      // begins 0,0,1
        add_byte(8'h5C, 1'b0);
        add_sync(GOOD, 1'b1, 1'b0, 1'b1);
        add_byte(8'h6E, 1'b1); add_byte(8'hD1, 1'b1);
        add_sync(GOOD, 1'b1, 1'b0, 1'b1);
        run_vecs(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Frame-synchronisation controller for a serial bit stream. It hunts for a fixed sync code with a sliding window, verifies the code recurs at the frame period, and declares lock. While locked it checks every expected sync slot and deserialises the payload bits into bytes. It sits between the serial receive front end and the byte-level packet logic, and owns all sync/lock sequencing for the link.

## Interface
- SYNC_CODE, 4'b1001 — sync pattern; bit [0] is the first bit received
- SYNC_LEN, 4 — width of SYNC_CODE in bits (2..16)
- PAYLOAD_BITS, 16 — payload bits per frame; a multiple of 8, at least 8
- LOCK_CNT, 2 — consecutive good syncs (including the hunt hit) needed to lock (>=1)
- UNLOCK_CNT, 3 — consecutive missed syncs in lock that drop lock (>=1)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- bit_in  in  1  serial data; sampled only when bit_vld=1
- bit_vld  in  1  qualifies bit_in for one cycle
- locked  out  1  level; 1 while in LOCK
- frame_start  out  1  one-cycle pulse; a sync passed while locked or on entry to LOCK
- sync_miss  out  1  one-cycle pulse; an expected sync slot mismatched while in LOCK
- byte_out  out  8  deserialised payload byte; first-received bit is byte_out[7]
- byte_vld  out  1  one-cycle pulse; byte_out is valid

## Operation
- Window: on each bit_vld, shift in bit_in as {bit_in, win[SYNC_LEN-1:1]}. It matches when win equals SYNC_CODE and at least SYNC_LEN bits have arrived since reset (fill counter saturates).
- Frame = PAYLOAD_BITS payload bits followed by SYNC_LEN sync bits. bit_cnt counts valid bits within the frame, starting at 0 after a sync decision.
- HUNT: tests for a match on every valid bit. On a match: go to VERIFY, good_cnt=1, bit_cnt=0. If LOCK_CNT==1, go straight to LOCK.
- VERIFY:
  - Counts bits with no byte output.
  - At the last bit of the sync slot (bit_cnt = PAYLOAD_BITS+SYNC_LEN-1): on a match, good_cnt++, and reaching LOCK_CNT enters LOCK. On a mismatch, return to HUNT.
  - bit_cnt resets to 0 at each slot end.
- LOCK:
  - Payload bits are shifted into the byte register. Every 8th payload bit produces byte_vld.
  - At sync slot end: a match gives frame_start and miss_cnt=0. A mismatch gives sync_miss and miss_cnt++.
  - When miss_cnt reaches UNLOCK_CNT, go to HUNT, locked=0, miss_cnt=0.
  - On any mismatch, bit_cnt still wraps to 0 (flywheel). The payload of the next frame is still emitted.
- The window is never cleared on state changes. HUNT may therefore match immediately on the next bit (overlapping search).
- bit_vld=0: all state, counters and the window hold. Pulses are not generated.

## Timing
- All outputs are registered. Every response appears the cycle after the clk edge that samples the causing bit_vld.
- locked rises in the same cycle as the frame_start for the lock-completing sync. It falls in the same cycle as the final sync_miss.
- byte_vld: one cycle, the cycle after the 8th bit of each byte. byte_out holds its value until the next byte_vld.
- Reset (asynchronous, any time including mid-frame):
  - Forces HUNT.
  - Clears the window, fill count, bit_cnt, good_cnt and miss_cnt.
  - locked=0, frame_start=0, sync_miss=0, byte_vld=0, byte_out=8'h00.
  - A partial byte is discarded.
- Back-to-back bit_vld on every cycle is supported with no throughput loss.

## Structure
- Package frame_sync_pkg holds:
  - the state enum HUNT/VERIFY/LOCK
  - default SYNC_CODE/SYNC_LEN constants
  - a helper giving the counter width, clog2(PAYLOAD_BITS+SYNC_LEN)
- Sub-module sync_window_match contains the shift window, fill counter and comparator, and outputs match. It is shared by HUNT and the slot check.
- The top level holds the FSM, counters and byte deserialiser.

## Test plan
All scenarios use default parameters.
- Reset: hold rst_n=0 while driving random bits -> all outputs 0. Drop rst_n mid-stream -> outputs clear in the same cycle, with no clk edge needed.
- Acquire: send 0,0, then 1,0,0,1, then payload 0xA5 0x3C, then 1,0,0,1, then payload 0x12 0x34, then 1,0,0,1 -> locked and frame_start=1 after the 2nd sync. byte_vld with 0x12 then 0x34. frame_start after the 3rd sync. No bytes from frame 1.
- Verify failure: send a sync, 16 bits, then slot bits 1,0,1,1 -> no lock and no byte_vld. A later correct 2-frame sequence then locks.
- Flywheel: while locked, corrupt 2 consecutive sync slots -> two sync_miss pulses, locked stays 1, bytes are still emitted. A good sync then gives frame_start. Corrupting 3 consecutive slots -> locked falls together with the 3rd sync_miss.
- Gapped input: repeat the acquire scenario with random 0–3 idle bit_vld=0 cycles between bits -> identical byte sequence and pulses.
- Overlap: send 1,0,0,1,0,0,1 in HUNT -> the first match fires after bit 4. The controller then enters VERIFY and does not re-hunt on bit 7.
